// File: rtl/uart_pwm_defs.sv
// Shared constants for the UART command frame protocol and PWM register map:
// frame sync byte, response codes, register addresses and parser state encoding.
package uart_pwm_defs;

   localparam logic [7:0] SYNC_BYTE  = 8'hA5;
   localparam logic [7:0] ACK_BYTE   = 8'h06;
   localparam logic [7:0] NAK_BYTE   = 8'h15;

   localparam logic [7:0] REG_CTRL   = 8'h00;
   localparam logic [7:0] REG_PERIOD = 8'h01;
   localparam logic [7:0] REG_DUTY   = 8'h02;

   // One state per frame byte still expected; IDLE waits for SYNC.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      DLO  = 3'd2,
      DHI  = 3'd3,
      CHK  = 3'd4
   } frame_state_t;

   // Frame checksum: XOR of the three payload bytes.
   function automatic logic [7:0] frame_chk(input logic [7:0] addr,
                                            input logic [7:0] dlo,
                                            input logic [7:0] dhi);
      return addr ^ dlo ^ dhi;
   endfunction

endpackage

// File: rtl/uart_cmd_ctrl_timeout.sv
// Inter-byte timeout for the command parser: counts idle cycles while a frame
// is in progress and flags expiry on the cycle the count reaches its limit.
module cmd_timeout #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,   // parser is mid-frame
   input  logic clear,    // a byte arrived this cycle
   output logic expire    // abort the frame this cycle
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // A received byte always wins over expiry, so the frame keeps going.
   assign expire = active && !clear && (count == LAST);

   // Idle-cycle counter; held at zero outside a frame and restarted by each byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!active || clear || expire) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses 5-byte frames (SYNC, ADDR, DLO, DHI, CHK)
// into PWM configuration registers and answers each frame with ACK or NAK.
module uart_cmd_ctrl
   import uart_pwm_defs::*;
#(
   parameter int          TIMEOUT_CYCLES = 50000,
   parameter logic [15:0] PERIOD_RST     = 16'd1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        pwm_en,
   output logic [15:0] pwm_period,
   output logic [15:0] pwm_duty,
   output logic        cfg_update,
   output logic [7:0]  resp_data,
   output logic        resp_valid,
   output logic        err_timeout
);

   frame_state_t state;
   logic [7:0]   addr_q;
   logic [7:0]   dlo_q;
   logic [7:0]   dhi_q;
   logic         expire;
   logic         frame_ok;
   logic [15:0]  wr_value;

   cmd_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .active (state != IDLE),
      .clear  (rx_valid),
      .expire (expire)
   );

   assign wr_value = {dhi_q, dlo_q};
   // Checksum must match and the address must name an existing register.
   assign frame_ok = (rx_data == frame_chk(addr_q, dlo_q, dhi_q)) && (addr_q <= REG_DUTY);

   // Frame parser with registered register file, response and strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         addr_q      <= '0;
         dlo_q       <= '0;
         dhi_q       <= '0;
         pwm_en      <= 1'b0;
         pwm_period  <= PERIOD_RST;
         pwm_duty    <= '0;
         cfg_update  <= 1'b0;
         resp_data   <= '0;
         resp_valid  <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout so every branch sees pre-edge values;
         // strobes default low here and are raised for exactly one cycle below.
         cfg_update  <= 1'b0;
         resp_valid  <= 1'b0;
         err_timeout <= 1'b0;
         if (rx_valid) begin
            case (state)
               IDLE: if (rx_data == SYNC_BYTE) state <= ADDR;
               ADDR: begin
                  addr_q <= rx_data;
                  state  <= DLO;
               end
               DLO: begin
                  dlo_q <= rx_data;
                  state <= DHI;
               end
               DHI: begin
                  dhi_q <= rx_data;
                  state <= CHK;
               end
               CHK: begin
                  state      <= IDLE;
                  resp_valid <= 1'b1;
                  if (frame_ok) begin
                     resp_data  <= ACK_BYTE;
                     cfg_update <= 1'b1;
                     case (addr_q)
                        REG_CTRL: pwm_en <= wr_value[0];
                        REG_PERIOD: begin
                           pwm_period <= wr_value;
                           // Shrinking the period drags duty down with it.
                           if (wr_value < pwm_duty) pwm_duty <= wr_value;
                        end
                        REG_DUTY: pwm_duty <= (wr_value > pwm_period) ? pwm_period : wr_value;
                        default: ;
                     endcase
                  end else begin
                     resp_data <= NAK_BYTE;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (expire) begin
            state       <= IDLE;
            err_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed frames for the key cases,
// then random frames checked against a byte-queue reference model.
module tb_uart_cmd_ctrl;

   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        pwm_en;
   logic [15:0] pwm_period;
   logic [15:0] pwm_duty;
   logic        cfg_update;
   logic [7:0]  resp_data;
   logic        resp_valid;
   logic        err_timeout;

   uart_cmd_ctrl #(
      .TIMEOUT_CYCLES (TO),
      .PERIOD_RST     (16'd1000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .pwm_en      (pwm_en),
      .pwm_period  (pwm_period),
      .pwm_duty    (pwm_duty),
      .cfg_update  (cfg_update),
      .resp_data   (resp_data),
      .resp_valid  (resp_valid),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: bytes of the frame collected so far plus register values.
   logic [7:0]  mq[$];
   logic        m_en;
   logic [15:0] m_per;
   logic [15:0] m_duty;
   logic [7:0]  m_resp;

   task automatic model_reset();
      mq.delete();
      m_en   = 1'b0;
      m_per  = 16'd1000;
      m_duty = 16'd0;
      m_resp = 8'h00;
   endtask

   task automatic model_byte(input logic [7:0] b, output logic ev, output logic cfg);
      logic [15:0] val;
      ev  = 1'b0;
      cfg = 1'b0;
      if (mq.size() == 0 && b != 8'hA5) return;
      mq.push_back(b);
      if (mq.size() == 5) begin
         ev  = 1'b1;
         val = {mq[3], mq[2]};
         if (mq[4] == (mq[1] ^ mq[2] ^ mq[3]) && mq[1] <= 8'h02) begin
            cfg    = 1'b1;
            m_resp = 8'h06;
            if (mq[1] == 8'h00) m_en = val[0];
            else if (mq[1] == 8'h01) begin
               m_per = val;
               if (m_duty > val) m_duty = val;
            end else m_duty = (val > m_per) ? m_per : val;
         end else begin
            m_resp = 8'h15;
         end
         mq.delete();
      end
   endtask

   task automatic check_regs();
      check("pwm_en", pwm_en, m_en);
      check("pwm_period", pwm_period, m_per);
      check("pwm_duty", pwm_duty, m_duty);
      check("duty_le_period", pwm_duty <= pwm_period, 1);
   endtask

   // Called at a negedge; drives one byte for one cycle and checks the cycle after.
   task automatic send_byte(input logic [7:0] b);
      logic ev, cfg;
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      model_byte(b, ev, cfg);
      check("resp_valid", resp_valid, ev);
      check("cfg_update", cfg_update, cfg);
      check("err_timeout", err_timeout, 0);
      check("resp_data", resp_data, m_resp);
      check_regs();
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk);
         check("gap_resp_valid", resp_valid, 0);
         check("gap_cfg_update", cfg_update, 0);
         check("gap_err_timeout", err_timeout, 0);
         check("gap_resp_data", resp_data, m_resp);
      end
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] lo, input logic [7:0] hi,
                             input logic [7:0] chk, input int maxgap);
      send_byte(8'hA5); gap($urandom_range(0, maxgap));
      send_byte(a);     gap($urandom_range(0, maxgap));
      send_byte(lo);    gap($urandom_range(0, maxgap));
      send_byte(hi);    gap($urandom_range(0, maxgap));
      send_byte(chk);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_state_idle", dut.state, 0);
      check("rst_pwm_en", pwm_en, 0);
      check("rst_pwm_period", pwm_period, 16'd1000);
      check("rst_pwm_duty", pwm_duty, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_strobes", {resp_valid, cfg_update, err_timeout}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first, pulses, resps;
      logic [7:0] a, lo, hi, chk, j;
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      model_reset();
      @(negedge clk);
      do_reset();
      gap(2);

      // Period 2000, then duty 500.
      send_frame(8'h01, 8'hD0, 8'h07, 8'hD6, 0);
      check("p2000_ack", resp_data, 8'h06);
      check("p2000_cfg", cfg_update, 1);
      check("p2000_val", pwm_period, 16'd2000);
      gap(1);
      send_frame(8'h02, 8'hF4, 8'h01, 8'hF7, 2);
      check("d500_val", pwm_duty, 16'd500);

      // Enable.
      send_frame(8'h00, 8'h01, 8'h00, 8'h01, 1);
      check("en_val", pwm_en, 1);
      check("en_ack", resp_data, 8'h06);

      // Bad checksum and bad address -> NAK, nothing changes.
      send_frame(8'h01, 8'hD0, 8'h07, 8'h00, 1);
      check("badchk_nak", resp_data, 8'h15);
      check("badchk_cfg", cfg_update, 0);
      check("badchk_period", pwm_period, 16'd2000);
      gap(1);
      send_frame(8'h05, 8'h00, 8'h00, 8'h05, 1);
      check("badaddr_nak", resp_data, 8'h15);
      check("badaddr_valid", resp_valid, 1);

      // From reset: duty 3000 clamps to 1000, then period 300 drags duty down.
      do_reset();
      send_frame(8'h02, 8'hB8, 8'h0B, 8'hB1, 0);
      check("clamp_duty", pwm_duty, 16'd1000);
      send_frame(8'h01, 8'h2C, 8'h01, 8'h2C, 0);
      check("shrink_period", pwm_period, 16'd300);
      check("shrink_duty", pwm_duty, 16'd300);

      // SYNC value inside the frame is plain data: period 0x00A5.
      send_frame(8'h01, 8'hA5, 8'h00, 8'hA4, 0);
      check("a5_data_period", pwm_period, 16'h00A5);

      // Reset mid-frame discards it; the next frame parses normally.
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'hD0);
      do_reset();
      send_frame(8'h02, 8'h64, 8'h00, 8'h66, 0);
      check("post_rst_duty", pwm_duty, 16'd100);
      check("post_rst_ack", resp_data, 8'h06);

      // Timeout after TO idle cycles mid-frame, no response, then a clean frame.
      send_byte(8'hA5); send_byte(8'h01);
      first = -1; pulses = 0; resps = 0;
      for (int i = 1; i <= TO + 20; i++) begin
         @(negedge clk);
         if (err_timeout) begin
            pulses++;
            if (first < 0) first = i;
         end
         if (resp_valid) resps++;
      end
      mq.delete();
      check("to_first_cycle", first, TO);
      check("to_pulses", pulses, 1);
      check("to_no_resp", resps, 0);
      check_regs();
      send_frame(8'h01, 8'h58, 8'h02, 8'h5B, 0);
      check("to_next_ack", resp_data, 8'h06);
      check("to_next_period", pwm_period, 16'd600);

      // Bytes landing exactly on the expiry cycle are accepted instead.
      send_byte(8'hA5); gap(TO - 1);
      send_byte(8'h01); gap(TO - 1);
      send_byte(8'hD0); gap(TO - 1);
      send_byte(8'h07); gap(TO - 1);
      send_byte(8'hD6);
      check("prio_ack", resp_data, 8'h06);
      check("prio_period", pwm_period, 16'd2000);

      // Random frames with junk between them.
      for (int f = 0; f < 150; f++) begin
         if ($urandom_range(0, 3) == 0) begin
            j = 8'($urandom);
            if (j == 8'hA5) j = 8'h5A;
            send_byte(j);
         end
         a  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 2));
         lo = 8'($urandom);
         hi = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
         if ($urandom_range(0, 5) == 0) lo = 8'hA5;
         chk = a ^ lo ^ hi;
         if ($urandom_range(0, 4) == 0) chk = chk ^ (8'h01 << $urandom_range(0, 7));
         send_frame(a, lo, hi, chk, 4);
         gap($urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, inter-byte timeout in clk cycles (>=2).
REQ-002 SHALL have parameter PERIOD_RST, default 16'd1000, reset value of pwm_period.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rx_data  input  8  received byte from the UART receiver.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-007 SHALL have port pwm_en  output  1  PWM enable (CTRL bit0).
REQ-008 SHALL have port pwm_period  output  16  PWM period in clk ticks.
REQ-009 SHALL have port pwm_duty  output  16  PWM high time in clk ticks, always <= pwm_period.
REQ-010 SHALL have port cfg_update  output  1  one-cycle pulse when any register is written.
REQ-011 SHALL have port resp_data  output  8  response byte for the UART transmitter: 0x06 ACK, 0x15 NAK.
REQ-012 SHALL have port resp_valid  output  1  one-cycle strobe for resp_data.
REQ-013 SHALL have port err_timeout  output  1  one-cycle pulse on frame abort by timeout.

Function
REQ-014 SHALL parse 5-byte frames: SYNC=0xA5, ADDR, DLO, DHI, CHK; CHK = ADDR ^ DLO ^ DHI.
REQ-015 SHALL use FSM states IDLE, ADDR, DLO, DHI, CHK, advancing one state per rx_valid; the CHK state returns to IDLE on its byte.
REQ-016 SHALL ignore non-0xA5 bytes in IDLE; 0xA5 received mid-frame SHALL be treated as data (no resync).
REQ-017 SHALL decode registers: 0x00 CTRL (bit0 -> pwm_en, other bits ignored), 0x01 PERIOD, 0x02 DUTY; value = {DHI,DLO}.
REQ-018 SHALL, on good CHK byte at cycle N with valid ADDR, update the register, pulse cfg_update and resp_valid with resp_data=0x06 at cycle N+1.
REQ-019 SHALL, on bad CHK or ADDR > 0x02, leave all registers unchanged, pulse resp_valid with 0x15 at N+1, and not pulse cfg_update.
REQ-020 SHALL clamp a DUTY write > current pwm_period to pwm_period.
REQ-021 SHALL, on a PERIOD write smaller than current pwm_duty, set pwm_duty to the new period in the same cycle.
REQ-022 SHALL count idle cycles in non-IDLE states, clearing on every rx_valid; when the count reaches TIMEOUT_CYCLES-1, it SHALL go to IDLE, pulse err_timeout, and send no response.
REQ-023 SHALL give rx_valid priority over a same-cycle timeout (byte accepted, counter cleared).
REQ-024 SHALL hold resp_data stable until the next resp_valid.

Reset
REQ-025 SHALL, on rst_n low, immediately force state IDLE, pwm_en=0, pwm_period=PERIOD_RST, pwm_duty=0, resp_data=0x00, all strobes 0, timeout counter 0.
REQ-026 SHALL discard any partial frame on reset mid-frame; the first frame after release SHALL be parsed normally.

Structure
REQ-027 SHALL take SYNC, ACK/NAK codes, register addresses and FSM state encodings from a shared package/include uart_pwm_defs.
REQ-028 SHALL be one module; an optional sub-module cmd_timeout (counter + expiry pulse) is permitted.

Verification
REQ-029 SHALL check: after reset -> pwm_en=0, pwm_period=1000, pwm_duty=0, no strobes.
REQ-030 SHALL check: A5 01 D0 07 D6 -> pwm_period=2000, cfg_update and resp 0x06 one cycle after the last byte; then A5 02 F4 01 F7 -> pwm_duty=500.
REQ-031 SHALL check: A5 00 01 00 01 -> pwm_en=1, ACK.
REQ-032 SHALL check: from reset, A5 02 B8 0B B1 (duty 3000) -> pwm_duty=1000; then period write 300 -> pwm_duty=300.
REQ-033 SHALL check: A5 01 D0 07 00 -> NAK 0x15, registers unchanged; A5 05 00 00 05 -> NAK.
REQ-034 SHALL check, with TIMEOUT_CYCLES=100: A5 01, then 100 idle cycles -> err_timeout pulse, no resp; next full frame -> ACK.
